// File: rtl/spi_aes_pkg.sv
// Shared definitions for the SPI AES master.
// Provides the FSM state encoding, the mode constants and a helper that sizes
// the outbound frame ({data_in, key}) from the key length in 32-bit words.
package spi_aes_pkg;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Operation select; also indexes the chip select of the matching slave.
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Outbound frame length in bits: one 128-bit block followed by the key.
  function automatic int unsigned frame_bits(input int unsigned nk);
    return 128 + nk * 32;
  endfunction

endpackage

// File: rtl/spi_aes_master_sclk_gen.sv
// SPI clock divider (mode 0, idles low).
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - run the divider; when low sclk is forced low and the phase restarts
//   sclk - SPI clock, CLK_DIV clk cycles per half period
//   rise - high in the clk cycle whose closing edge drives sclk high
//   fall - high in the clk cycle whose closing edge drives sclk low
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  if (CLK_DIV == 0) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          edge_now;

  assign edge_now = en && (cnt_q == LAST);
  assign rise     = edge_now && !sclk_q;
  assign fall     = edge_now && sclk_q;
  assign sclk     = sclk_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (edge_now) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_aes_master.sv
// SPI master that ships {data_in, key} to an external AES slave and reads the
// 128-bit result back.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start, mode       - request a transaction; 0 = encrypt, 1 = decrypt
//   data_in, key      - block and NK*32-bit key latched on acceptance
//   data_out, done    - result block, valid with the one-cycle done pulse
//   busy              - high whenever the FSM is not idle
//   sclk, mosi, miso  - SPI mode 0 bus
//   cs_n              - active-low selects: [0] cipher, [1] inverse cipher
module spi_aes_master
  import spi_aes_pkg::*;
#(
  parameter int unsigned NK        = 4,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned SLAVE_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [127:0]    data_in,
  input  logic [NK*32-1:0] key,
  output logic [127:0]    data_out,
  output logic            done,
  output logic            busy,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic [1:0]      cs_n
);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("NK must be 4, 6 or 8");
  end

  localparam int unsigned F         = frame_bits(NK);
  localparam logic [31:0] SEND_LAST = 32'(F - 1);
  localparam logic [31:0] WAIT_LAST = (SLAVE_LAT == 0) ? 32'd0 : 32'(SLAVE_LAT - 1);
  localparam logic [31:0] RECV_LAST = 32'd127;

  logic [2:0]   state_q, state_d;
  logic         mode_q, mode_d;
  logic [F-1:0] sreg_q, sreg_d;
  logic [127:0] rx_q, rx_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [127:0] data_out_q, data_out_d;
  logic         done_q, done_d;

  logic sclk_en, sclk_rise, sclk_fall, bus_active;

  // Divider runs only while the bus is in use.
  assign sclk_en    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus_active = sclk_en;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sclk_en),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sreg_d     = sreg_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding off while done is high keeps each result visible for its pulse.
        if (start && !done_q) begin
          sreg_d  = {data_in, key};
          mode_d  = mode;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sclk_fall) begin
          sreg_d = sreg_q << 1;
          if (cnt_q == SEND_LAST) begin
            cnt_d   = '0;
            state_d = (SLAVE_LAT == 0) ? ST_RECV : ST_WAIT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_WAIT: begin
        if (sclk_fall) begin
          if (cnt_q == WAIT_LAST) begin
            cnt_d   = '0;
            state_d = ST_RECV;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_RECV: begin
        if (sclk_rise) begin
          rx_d = {rx_q[126:0], miso};
        end
        if (sclk_fall) begin
          if (cnt_q == RECV_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_DONE: begin
        data_out_d = rx_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ENC;
      sreg_q     <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sreg_q     <= sreg_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign data_out = data_out_q;
  assign mosi     = (state_q == ST_SEND) ? sreg_q[F-1] : 1'b0;
  assign cs_n     = {~(bus_active && (mode_q == MODE_DEC)),
                     ~(bus_active && (mode_q == MODE_ENC))};

endmodule

// File: tb/tb_spi_aes_master.sv
// Bench for spi_aes_master: three instances cover NK=4/CLK_DIV=1/SLAVE_LAT=0,
// NK=4/CLK_DIV=2/SLAVE_LAT=4 and NK=8/CLK_DIV=1/SLAVE_LAT=0. A slave model per
// instance collects mosi on sclk rises and returns a response block on miso.
module tb_spi_aes_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         start_a [3];
  logic         mode_a  [3];
  logic         miso_a  [3];
  logic [127:0] din_a   [3];
  logic [255:0] key_a   [3];
  logic [127:0] dout_a  [3];
  logic         done_a  [3];
  logic         busy_a  [3];
  logic         sclk_a  [3];
  logic         mosi_a  [3];
  logic [1:0]   csn_a   [3];

  // Frame bits, slave latency and divider of each instance.
  int fb   [3];
  int lat  [3];
  int cdiv [3];

  // Slave model state (written only by the monitor, except resp).
  int           rises     [3];
  logic [383:0] recv      [3];
  logic [1:0]   seen_cs   [3];
  int           idle_bad  [3];
  logic [127:0] resp      [3];
  logic         prev_sclk [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_aes_master #(.NK(4), .CLK_DIV(1), .SLAVE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mode(mode_a[0]), .data_in(din_a[0]),
    .key(key_a[0][127:0]), .data_out(dout_a[0]), .done(done_a[0]), .busy(busy_a[0]),
    .sclk(sclk_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0]), .cs_n(csn_a[0])
  );

  spi_aes_master #(.NK(4), .CLK_DIV(2), .SLAVE_LAT(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mode(mode_a[1]), .data_in(din_a[1]),
    .key(key_a[1][127:0]), .data_out(dout_a[1]), .done(done_a[1]), .busy(busy_a[1]),
    .sclk(sclk_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1]), .cs_n(csn_a[1])
  );

  spi_aes_master #(.NK(8), .CLK_DIV(1), .SLAVE_LAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .mode(mode_a[2]), .data_in(din_a[2]),
    .key(key_a[2]), .data_out(dout_a[2]), .done(done_a[2]), .busy(busy_a[2]),
    .sclk(sclk_a[2]), .mosi(mosi_a[2]), .miso(miso_a[2]), .cs_n(csn_a[2])
  );

  // Slave model: rise index k < F is a frame bit, the next SLAVE_LAT rises are
  // idle, the following 128 rises read the response MSB first. miso is updated
  // after each falling edge so it is stable when the master samples it.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!busy_a[d]) begin
        rises[d]    = 0;
        seen_cs[d]  = 2'b00;
        idle_bad[d] = 0;
        miso_a[d]   = 1'b0;
      end else begin
        seen_cs[d] = seen_cs[d] | ~csn_a[d];
        if (sclk_a[d] && !prev_sclk[d]) begin
          if (rises[d] < fb[d]) begin
            recv[d] = {recv[d][382:0], mosi_a[d]};
          end else if (rises[d] < fb[d] + lat[d]) begin
            if (mosi_a[d] !== 1'b0) idle_bad[d] = idle_bad[d] + 1;
          end
          rises[d] = rises[d] + 1;
        end
        if (!sclk_a[d] && prev_sclk[d]) begin
          int j;
          j = rises[d] - fb[d] - lat[d];
          miso_a[d] = (j >= 0 && j < 128) ? resp[d][127 - j] : 1'b0;
        end
      end
      prev_sclk[d] = sclk_a[d];
    end
  end

  // One full transaction on instance d, checked against the slave model.
  task automatic run_txn(input int d, input logic m, input logic [127:0] din,
                         input logic [255:0] k, input logic [127:0] rs,
                         input bit repulse, input string tag);
    int           n;
    int           exp_lat;
    bit           got;
    logic [383:0] exp_frame;
    logic [383:0] mask;
    logic [1:0]   exp_cs;
    exp_lat   = (fb[d] + 128 + lat[d]) * 2 * cdiv[d] + 1;
    exp_frame = (fb[d] == 384) ? {din, k} : {128'b0, din, k[127:0]};
    mask      = (fb[d] == 384) ? {384{1'b1}} : {128'b0, {256{1'b1}}};
    exp_cs    = m ? 2'b10 : 2'b01;
    resp[d]   = rs;
    @(negedge clk);
    start_a[d] = 1'b1;
    mode_a[d]  = m;
    din_a[d]   = din;
    key_a[d]   = k;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the latched copy must be used.
    start_a[d] = 1'b0;
    mode_a[d]  = ~m;
    din_a[d]   = {$urandom, $urandom, $urandom, $urandom};
    key_a[d]   = {8{$urandom}};
    n   = 0;
    got = 1'b0;
    while (!got && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        n_checks++;
        if (busy_a[d] !== 1'b1 || csn_a[d] !== ~exp_cs) begin
          n_fail++;
          $display("FAIL %s first cycle: busy=%b cs_n=%b, required busy=1 cs_n=%b",
                   tag, busy_a[d], csn_a[d], ~exp_cs);
        end
      end
      if (repulse && n == 100) begin
        start_a[d] = 1'b1;
        mode_a[d]  = ~m;
      end
      if (repulse && n == 101) start_a[d] = 1'b0;
      if (done_a[d] === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, required at %0d", tag, n, exp_lat);
      return;
    end
    if (n != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, n, exp_lat);
    end
    n_checks++;
    if (dout_a[d] !== rs) begin
      n_fail++;
      $display("FAIL %s data_out: got %h, required %h", tag, dout_a[d], rs);
    end
    n_checks++;
    if (rises[d] != fb[d] + lat[d] + 128) begin
      n_fail++;
      $display("FAIL %s sclk periods: got %0d, required %0d", tag, rises[d],
               fb[d] + lat[d] + 128);
    end
    n_checks++;
    if ((recv[d] & mask) !== exp_frame) begin
      n_fail++;
      $display("FAIL %s frame: got %h, required %h", tag, recv[d] & mask, exp_frame);
    end
    n_checks++;
    if (seen_cs[d] !== exp_cs) begin
      n_fail++;
      $display("FAIL %s selects used: got %b, required %b", tag, seen_cs[d], exp_cs);
    end
    n_checks++;
    if (idle_bad[d] != 0 || csn_a[d] !== 2'b11 || busy_a[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done cycle: idle_bad=%0d cs_n=%b busy=%b, required 0 11 0",
               tag, idle_bad[d], csn_a[d], busy_a[d]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done_a[d] !== 1'b0 || dout_a[d] !== rs) begin
      n_fail++;
      $display("FAIL %s after done: done=%b data_out=%h, required 0 %h",
               tag, done_a[d], dout_a[d], rs);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy_a[d] !== 1'b0 || done_a[d] !== 1'b0 || sclk_a[d] !== 1'b0 ||
          mosi_a[d] !== 1'b0 || csn_a[d] !== 2'b11 || dout_a[d] !== 128'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: busy=%b done=%b sclk=%b mosi=%b cs_n=%b dout=%h, required 0 0 0 0 11 0",
                 tag, d, busy_a[d], done_a[d], sclk_a[d], mosi_a[d], csn_a[d], dout_a[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    run_txn(0, 1'b0, 128'h00112233445566778899aabbccddeeff,
            {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, "encrypt");
  endtask

  task automatic test_decrypt_latency();
    run_txn(1, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h00112233445566778899aabbccddeeff, 1'b0, "decrypt");
  endtask

  task automatic test_nk8();
    logic [255:0] k;
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_txn(2, 1'b0, 128'h00112233445566778899aabbccddeeff, k,
            128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, "nk8");
    n_checks++;
    if (recv[2][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL nk8 last bit: got %b, required key[0]=1", recv[2][0]);
    end
  endtask

  task automatic test_ignored_start();
    int extra;
    run_txn(0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {128'b0, {4{$urandom}}},
            {$urandom, $urandom, $urandom, $urandom}, 1'b1, "ignored_start");
    extra = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done_a[0] === 1'b1 || busy_a[0] === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignored_start extra activity: got %0d cycles, required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_a[0] = 1'b1;
    mode_a[0]  = 1'b0;
    din_a[0]   = {4{$urandom}};
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst        = 1'b1;
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    start_a[0] = 1'b0;
    check_idle("reset_mid");
    run_txn(0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, {128'b0, {4{$urandom}}},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int   d;
      logic m;
      d = $urandom_range(0, 2);
      m = 1'($urandom_range(0, 1));
      run_txn(d, m, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, "random");
    end
  endtask

  initial begin
    fb   = '{256, 256, 384};
    lat  = '{0, 4, 0};
    cdiv = '{1, 2, 1};
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0;
      mode_a[d]  = 1'b0;
      din_a[d]   = '0;
      key_a[d]   = '0;
      resp[d]    = '0;
    end
    test_reset();
    test_encrypt();
    test_decrypt_latency();
    test_nk8();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
